seven_seg_mux_ctrl: RTL
=======================

Name: seven_seg_mux_ctrl

Overview:
Parametrised multiplexed seven-segment display controller for N common-anode hex digits. It adds a programmable refresh prescaler, global PWM brightness, per-digit blink and a guaranteed inter-digit blanking step against ghosting. It sits between the display-data registers and the board's segment/anode pins, and exports a frame strobe for display-synchronous updates.

Parameters:
DIGITS, 4, number of multiplexed digits (>=2)
PRESCALE_WIDTH, 16, prescaler width; one PWM sub-step = 2^PRESCALE_WIDTH clk cycles
BRIGHT_WIDTH, 4, brightness resolution; one digit slot = 2^BRIGHT_WIDTH sub-steps
BLINK_FRAMES, 32, full frames per blink half-period (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
digits  in  4*DIGITS  hex value per digit; digit i = digits[4i+3:4i]
decimal_points  in  DIGITS  1 = DP lit for digit i
enables  in  DIGITS  1 = digit i may light; 0 = digit i blank
blink  in  DIGITS  1 = digit i blinks at the blink rate
brightness  in  BRIGHT_WIDTH  lit sub-steps per slot; 0 = dark
segments  out  8  registered, active-low; [6:0] = g..a, [7] = DP
anodes  out  DIGITS  registered, active-low digit select
frame_tick  out  1  one-cycle pulse at the start of each frame

Behaviour:
- Reset is asynchronous and active-high. It takes effect immediately, including mid-frame, and clears prescaler, pwm_cnt, index, blink_cnt and blink_phase to 0. Outputs during and after reset: anodes all 1, segments 8'hFF, frame_tick 0.
- prescaler free-runs from 0 to 2^PRESCALE_WIDTH-1, then wraps.
- On each prescaler wrap, pwm_cnt increments.
- On each pwm_cnt wrap, index advances. index wraps from DIGITS-1 to 0; non-power-of-two DIGITS must wrap correctly.
- Slot length = 2^(PRESCALE_WIDTH+BRIGHT_WIDTH) cycles. Frame length = DIGITS slots.
- Digit index is lit in a sub-step when all of the following hold:
  - enables[index] = 1
  - pwm_cnt < brightness
  - NOT (blink[index] AND blink_phase)
- Blanking: since brightness <= 2^BRIGHT_WIDTH-1, the last sub-step of every slot is always dark. This gives a guaranteed blank step before every index change.
- When lit, at most one anode is low: anodes[index] = 0, all others 1. segments[6:0] = hex decode of the digit (table below). segments[7] = ~decimal_points[index].
- When not lit: anodes all 1, segments 8'hFF.
- Hex decode, active-low gfedcba: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, B 83, C C6, D A1, E 86, F 8E (values include DP off).
- Latency: outputs are registered from the current counter state and inputs. Any input change appears on the pins exactly one cycle later. Inputs are not latched per frame.
- frame_tick is high for exactly the one cycle in which the registered outputs first present index 0 of a new frame. It pulses every frame regardless of brightness, enables or blink. It does not pulse on the first frame after reset.
- Blink: blink_cnt counts completed frames from 0 to BLINK_FRAMES-1. On wrap, blink_phase toggles. Phase 0 = visible, phase 1 = hidden. All blinking digits share the phase.
- Simultaneous events: a wrap of the prescaler, pwm_cnt, index and blink counters all resolve in the same cycle with no skipped or double step.
- Brightness changes mid-slot take effect on the next cycle's comparison. No glitch beyond one sub-step granularity is permitted.

Test Plan:
(Bench parameters: PRESCALE_WIDTH=2, BRIGHT_WIDTH=2, DIGITS=4, BLINK_FRAMES=2. Sub-step = 4 cycles, slot = 16 cycles, frame = 64 cycles.)
1. Reset: assert reset mid-slot while digit 2 is lit -> anodes 4'b1111 and segments 8'hFF before the next clk edge. After release, the first lit digit is index 0.
2. Basic scan: digits=16'h3210, brightness=3, enables=4'hF, decimal_points=0 -> anodes 1110 for 12 cycles with segments C0, then 1111 for 4 cycles, then 1101 with F9, then A4, then B0. frame_tick fires every 64 cycles.
3. Dimming: brightness=1 -> each digit is lit 4 of 16 cycles. brightness=0 -> anodes stay 1111 permanently while frame_tick still pulses every 64 cycles.
4. Enables and DP: enables=4'b0101, decimal_points=4'b0001, digits=16'hFFFF -> digit 0 shows 8'h0E, digit 2 shows 8'h8E, and anodes[1] and anodes[3] are never 0.
5. Blink: blink=4'b0100, brightness=3 -> digit 2 is lit in frames 0-1, dark in frames 2-3, lit in frames 4-5. Other digits are unaffected.
6. Width and wrap: DIGITS=6, digits=24'hABCDEF -> index wraps from 5 to 0, frame = 96 cycles, and the segment sequence is 86, A1, C6, 83, 88, 8E.

Source files
------------

// File: rtl/seven_seg_mux_ctrl.sv
// Multiplexed common-anode seven-segment controller: prescaled digit scan,
// PWM brightness, per-digit blink and a guaranteed dark sub-step between digits.
module seven_seg_mux_ctrl #(
  parameter int DIGITS         = 4,
  parameter int PRESCALE_WIDTH = 16,
  parameter int BRIGHT_WIDTH   = 4,
  parameter int BLINK_FRAMES   = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*DIGITS-1:0]     digits,
  input  logic [DIGITS-1:0]       decimal_points,
  input  logic [DIGITS-1:0]       enables,
  input  logic [DIGITS-1:0]       blink,
  input  logic [BRIGHT_WIDTH-1:0] brightness,
  output logic [7:0]              segments,
  output logic [DIGITS-1:0]       anodes,
  output logic                    frame_tick
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(BLINK_FRAMES - 1);

  logic [PRESCALE_WIDTH-1:0] prescaler;
  logic [BRIGHT_WIDTH-1:0]   pwm_cnt;
  logic [IDX_W-1:0]          index;
  logic [BLK_W-1:0]          blink_cnt;
  logic                      blink_phase;
  logic                      frame_start_p0;

  logic                      pre_wrap, pwm_wrap, idx_wrap, blk_wrap;
  logic                      lit;
  logic [3:0]                cur_digit;
  logic [DIGITS-1:0]         sel;

  // Active-low gfedcba pattern for one hex nibble.
  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    case (v)
      4'h0:    hex_decode = 7'h40;
      4'h1:    hex_decode = 7'h79;
      4'h2:    hex_decode = 7'h24;
      4'h3:    hex_decode = 7'h30;
      4'h4:    hex_decode = 7'h19;
      4'h5:    hex_decode = 7'h12;
      4'h6:    hex_decode = 7'h02;
      4'h7:    hex_decode = 7'h78;
      4'h8:    hex_decode = 7'h00;
      4'h9:    hex_decode = 7'h10;
      4'hA:    hex_decode = 7'h08;
      4'hB:    hex_decode = 7'h03;
      4'hC:    hex_decode = 7'h46;
      4'hD:    hex_decode = 7'h21;
      4'hE:    hex_decode = 7'h06;
      default: hex_decode = 7'h0E;
    endcase
  endfunction

  // All wrap conditions chain off one another so a full rollover resolves in a single cycle.
  always_comb begin
    pre_wrap = &prescaler;
    pwm_wrap = pre_wrap && (&pwm_cnt);
    idx_wrap = pwm_wrap && (index == LAST_IDX);
    blk_wrap = idx_wrap && (blink_cnt == LAST_BLK);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler   <= '0;
      pwm_cnt     <= '0;
      index       <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      prescaler <= prescaler + PRESCALE_WIDTH'(1);
      if (pre_wrap) pwm_cnt <= pwm_cnt + BRIGHT_WIDTH'(1);
      if (pwm_wrap) index <= idx_wrap ? '0 : index + IDX_W'(1);
      if (idx_wrap) blink_cnt <= blk_wrap ? '0 : blink_cnt + BLK_W'(1);
      if (blk_wrap) blink_phase <= ~blink_phase;
    end
  end

  // Max brightness is one short of the slot length, so the final sub-step is always dark.
  always_comb begin
    cur_digit = digits[{index, 2'b00} +: 4];
    sel       = DIGITS'(1) << index;
    lit       = enables[index] && (pwm_cnt < brightness) && !(blink[index] && blink_phase);
  end

  // Output register stage; frame_start_p0 delays the wrap so the tick lines up with index 0 on the pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      segments       <= 8'hFF;
      anodes         <= '1;
      frame_start_p0 <= 1'b0;
      frame_tick     <= 1'b0;
    end else begin
      segments       <= lit ? {~decimal_points[index], hex_decode(cur_digit)} : 8'hFF;
      anodes         <= lit ? ~sel : '1;
      frame_start_p0 <= idx_wrap;
      frame_tick     <= frame_start_p0;
    end
  end

endmodule
